// File: rtl/sram_ctrl_pkg.sv
// Shared constants, request bundle and write-mask helper for the
// 128x4096 SRAM request front-end.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DATA_W = 128;
  localparam int SRAM_BE_W   = SRAM_DATA_W / 8;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_BE_W-1:0]   be;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

  // Expands active-high byte enables into the SRAM's active-low bit mask.
  function automatic logic [SRAM_DATA_W-1:0] be2wen(input logic [SRAM_BE_W-1:0] be);
    logic [SRAM_DATA_W-1:0] wen;
    for (int i = 0; i < SRAM_DATA_W; i++) begin
      wen[i] = ~be[i/8];
    end
    return wen;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous in-order FIFO holding captured read data until the
// response channel takes it.
module sram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 128,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap modulo DEPTH so non power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/sram_128x4096_req_ctrl.sv
// Bus-facing request front-end for the 128x4096 single-port SRAM: drives
// the SRAM pins directly from accepted requests and queues read data.
module sram_128x4096_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int RSP_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                sram_cen_o,
  output logic                sram_gwen_o,
  output logic [DATA_W-1:0]   sram_wen_o,
  output logic [ADDR_W-1:0]   sram_a_o,
  output logic [DATA_W-1:0]   sram_d_o,
  input  logic [DATA_W-1:0]   sram_q_i,
  output logic                rd_pending_o
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int CW    = CNT_W + 1;

  logic              rd_pending_q, rd_pending_d;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              fifo_push, rsp_pop;
  logic              accept, rd_accept, wr_accept, has_credit;
  logic [CW-1:0]     slots_used, slots_avail;
  logic [DATA_W-1:0] wen_mask;

  assign rsp_pop = rsp_valid_o & rsp_ready_i;

  // A read in flight already owns a FIFO slot; a same-cycle pop frees one.
  assign slots_used  = CW'(fifo_count) + CW'(rd_pending_q);
  assign slots_avail = CW'(RSP_DEPTH) + CW'(rsp_pop);
  assign has_credit  = slots_used < slots_avail;

  assign req_ready_o = ~rst_i & (req_we_i | has_credit);
  assign accept      = req_valid_i & req_ready_o;
  assign rd_accept   = accept & ~req_we_i;
  assign wr_accept   = accept & req_we_i;

  always_comb begin
    wen_mask = '1;
    for (int i = 0; i < DATA_W; i++) begin
      wen_mask[i] = ~req_be_i[i/8];
    end
  end

  // GWEN/WEN only go active for an accepted write, so the pins sit at
  // their idle levels whenever nothing is being written.
  assign sram_cen_o  = ~(accept & (~req_we_i | (|req_be_i)));
  assign sram_gwen_o = ~wr_accept;
  assign sram_wen_o  = wr_accept ? wen_mask : '1;
  assign sram_a_o    = req_addr_i;
  assign sram_d_o    = req_wdata_i;

  assign rd_pending_d = rd_accept;
  assign rd_pending_o = rd_pending_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pending_q <= 1'b0;
    end else begin
      rd_pending_q <= rd_pending_d;
    end
  end

  assign fifo_push   = rd_pending_q & (~fifo_full | rsp_pop);
  assign rsp_valid_o = ~fifo_empty;

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (sram_q_i),
    .pop_i   (rsp_pop),
    .rdata_o (rsp_rdata_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_sram_128x4096_req_ctrl.sv
// Self-checking bench for sram_128x4096_req_ctrl with a behavioural SRAM
// and a scoreboard fed from accepted requests.
module tb_sram_128x4096_req_ctrl;

  localparam int AW = 12;
  localparam int DW = 128;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready_o;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [BW-1:0] req_be = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid_o;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata_o;
  logic          sram_cen_o, sram_gwen_o;
  logic [DW-1:0] sram_wen_o;
  logic [AW-1:0] sram_a_o;
  logic [DW-1:0] sram_d_o;
  logic [DW-1:0] sram_q = '0;
  logic          rd_pending_o;

  always #5 clk = ~clk;

  sram_128x4096_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_be_i     (req_be),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata_o),
    .sram_cen_o   (sram_cen_o),
    .sram_gwen_o  (sram_gwen_o),
    .sram_wen_o   (sram_wen_o),
    .sram_a_o     (sram_a_o),
    .sram_d_o     (sram_d_o),
    .sram_q_i     (sram_q),
    .rd_pending_o (rd_pending_o)
  );

  int     n_chk = 0;
  int     n_pass = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural SRAM: registered read, active-low bit-masked write.
  logic [DW-1:0] sram_mem [4096];
  logic [DW-1:0] ref_mem  [4096];

  always @(posedge clk) begin
    if (!sram_cen_o) begin
      if (!sram_gwen_o)
        sram_mem[sram_a_o] <= (sram_mem[sram_a_o] & sram_wen_o) | (sram_d_o & ~sram_wen_o);
      else
        sram_q <= sram_mem[sram_a_o];
    end
  end

  // Scoreboard: expectations pushed at read accept, compared at response handshake.
  logic [DW-1:0] exp_q [$];
  longint        acc_q [$];
  int            n_rsp = 0;
  longint        first_rsp = 0, last_rsp = 0, last_lat = 0;

  always @(negedge clk) begin
    logic [DW-1:0] m;
    logic [DW-1:0] e;
    longint        a;
    if (rsp_valid_o && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_spurious", 128'(rsp_valid_o), 128'(0));
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("rsp_data", rsp_rdata_o, e);
        last_lat = cyc - a;
        if (n_rsp == 0) first_rsp = cyc;
        last_rsp = cyc;
        n_rsp++;
      end
    end
    if (req_valid && req_ready_o) begin
      if (req_we) begin
        for (int b = 0; b < BW; b++) m[8*b +: 8] = {8{req_be[b]}};
        ref_mem[req_addr] = (ref_mem[req_addr] & ~m) | (req_wdata & m);
      end else begin
        exp_q.push_back(ref_mem[req_addr]);
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                      input logic [DW-1:0] wd, input int max_cyc, output logic acc);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    acc = 1'b0;
    for (int i = 0; i < max_cyc && !acc; i++) begin
      @(negedge clk);
      acc = req_ready_o;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic send_ok(input string name, input logic we, input logic [AW-1:0] addr,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
    logic acc;
    send(we, addr, be, wd, 20, acc);
    chk(name, 128'(acc), 128'(1));
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_rsp(input string name, input logic [DW-1:0] exp);
    logic got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = rsp_valid_o && rsp_ready;
      if (got) chk(name, rsp_rdata_o, exp);
      @(posedge clk); #1;
    end
    if (!got) chk({name, "_timeout"}, 128'(got), 128'(1));
  endtask

  typedef struct {
    logic          valid;
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    logic          e_ready;
    logic          e_cen;
    logic          e_gwen;
    logic [DW-1:0] e_wen;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic acc;
    longint t0;
    for (int i = 0; i < 4096; i++) begin
      sram_mem[i] = {4{20'hA5A5A, i[11:0]}};
      ref_mem[i]  = {4{20'hA5A5A, i[11:0]}};
    end

    vt[0] = '{1'b0, 1'b0, 12'h000, 16'h0000, 128'h0, 1'b1, 1'b1, 1'b1, '1};
    vt[1] = '{1'b1, 1'b0, 12'h001, 16'h0000, 128'h0, 1'b1, 1'b0, 1'b1, '1};
    vt[2] = '{1'b1, 1'b1, 12'h040, 16'hFFFF, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
              1'b1, 1'b0, 1'b0, 128'h0};
    vt[3] = '{1'b1, 1'b1, 12'h041, 16'h0001, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_00C3,
              1'b1, 1'b0, 1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00};
    vt[4] = '{1'b1, 1'b1, 12'h042, 16'h8000, 128'h9900_0000_0000_0000_0000_0000_0000_0000,
              1'b1, 1'b0, 1'b0, 128'h00FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};

    // Reset: pins idle and no request taken even with valid asserted.
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 128'(req_ready_o), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
    chk("rst_rd_pending", 128'(rd_pending_o), 128'(0));
    chk("rst_cen", 128'(sram_cen_o), 128'(1));
    chk("rst_gwen", 128'(sram_gwen_o), 128'(1));
    chk("rst_wen", sram_wen_o, '1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 128'(req_ready_o), 128'(1));
    chk("idle_cen", 128'(sram_cen_o), 128'(1));
    chk("idle_gwen", 128'(sram_gwen_o), 128'(1));
    chk("idle_wen", sram_wen_o, '1);
    @(posedge clk); #1;

    // Pin mapping vectors.
    for (int i = 0; i < 5; i++) begin
      req_valid = vt[i].valid; req_we = vt[i].we; req_addr = vt[i].addr;
      req_be = vt[i].be; req_wdata = vt[i].wd;
      @(negedge clk);
      if (vt[i].valid) chk($sformatf("vec%0d_ready", i), 128'(req_ready_o), 128'(vt[i].e_ready));
      chk($sformatf("vec%0d_cen", i), 128'(sram_cen_o), 128'(vt[i].e_cen));
      chk($sformatf("vec%0d_gwen", i), 128'(sram_gwen_o), 128'(vt[i].e_gwen));
      chk($sformatf("vec%0d_wen", i), sram_wen_o, vt[i].e_wen);
      chk($sformatf("vec%0d_a", i), 128'(sram_a_o), 128'(vt[i].addr));
      chk($sformatf("vec%0d_d", i), sram_d_o, vt[i].wd);
      @(posedge clk); #1;
    end
    idle(4);

    // Full write then read-back with latency check.
    send_ok("wr005", 1'b1, 12'h005, 16'hFFFF, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
    send_ok("rd005", 1'b0, 12'h005, 16'h0000, 128'h0);
    @(negedge clk);
    chk("rd005_not_yet", 128'(rsp_valid_o), 128'(0));
    @(posedge clk); #1;
    expect_rsp("rd005_data", 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
    chk("rd005_latency", 128'(last_lat), 128'(2));

    // Partial write onto 0x55 background; zero-enable write is a no-op.
    send_ok("wr010_full", 1'b1, 12'h010, 16'hFFFF, {16{8'h55}});
    send_ok("wr010_byte0", 1'b1, 12'h010, 16'h0001, 128'hAA);
    send_ok("rd010", 1'b0, 12'h010, 16'h0000, 128'h0);
    expect_rsp("rd010_data", 128'h5555_5555_5555_5555_5555_5555_5555_55AA);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h010; req_be = '0; req_wdata = '0;
    @(negedge clk);
    chk("be0_ready", 128'(req_ready_o), 128'(1));
    chk("be0_cen", 128'(sram_cen_o), 128'(1));
    @(posedge clk); #1;
    send_ok("rd010b", 1'b0, 12'h010, 16'h0000, 128'h0);
    expect_rsp("be0_unchanged", 128'h5555_5555_5555_5555_5555_5555_5555_55AA);
    idle(2);

    // Back-to-back reads at full rate.
    rsp_ready = 1'b1; n_rsp = 0; t0 = cyc;
    for (int a = 0; a < 8; a++) send_ok($sformatf("b2b_acc%0d", a), 1'b0, 12'(a), 16'h0, 128'h0);
    chk("b2b_cycles", 128'(cyc - t0), 128'(8));
    idle(6);
    chk("b2b_nrsp", 128'(n_rsp), 128'(8));
    chk("b2b_span", 128'(last_rsp - first_rsp), 128'(7));

    // Backpressure: two reads fit, further reads stall, writes still pass.
    rsp_ready = 1'b0; n_rsp = 0;
    send_ok("bp_rd20", 1'b0, 12'h020, 16'h0, 128'h0);
    send_ok("bp_rd21", 1'b0, 12'h021, 16'h0, 128'h0);
    send(1'b0, 12'h022, 16'h0, 128'h0, 4, acc);
    chk("bp_rd22_stall", 128'(acc), 128'(0));
    send(1'b0, 12'h023, 16'h0, 128'h0, 2, acc);
    chk("bp_rd23_stall", 128'(acc), 128'(0));
    chk("bp_rsp_valid", 128'(rsp_valid_o), 128'(1));
    chk("bp_no_pending", 128'(rd_pending_o), 128'(0));
    send(1'b1, 12'h030, 16'hFFFF, 128'hCAFE, 2, acc);
    chk("bp_write_pass", 128'(acc), 128'(1));
    chk("bp_nrsp0", 128'(n_rsp), 128'(0));
    rsp_ready = 1'b1;
    send_ok("bp_rd22", 1'b0, 12'h022, 16'h0, 128'h0);
    send_ok("bp_rd23", 1'b0, 12'h023, 16'h0, 128'h0);
    idle(6);
    chk("bp_nrsp4", 128'(n_rsp), 128'(4));

    // Reset with a full FIFO and a read in flight.
    rsp_ready = 1'b0;
    send_ok("mr_rd50", 1'b0, 12'h050, 16'h0, 128'h0);
    send_ok("mr_rd51", 1'b0, 12'h051, 16'h0, 128'h0);
    chk("mr_pending_before", 128'(rd_pending_o), 128'(1));
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    exp_q.delete(); acc_q.delete();
    rst = 1'b0; rsp_ready = 1'b1; n_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("mr_rsp_valid%0d", i), 128'(rsp_valid_o), 128'(0));
      @(posedge clk); #1;
    end
    chk("mr_rd_pending", 128'(rd_pending_o), 128'(0));
    chk("mr_nrsp", 128'(n_rsp), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
